// File: rtl/trace_capture.sv
// Trace sink for the processor debug port. It records one {PC,IR} entry per newly
// decoded instruction into a first-word-fall-through FIFO and stops after the halt opcode.
module trace_capture #(
  parameter int          DEPTH        = 16,
  parameter logic [3:0]  DECODE_STATE = 4'h2,
  parameter logic [3:0]  HALT_OP      = 4'h5,
  localparam int         AW           = $clog2(DEPTH),
  localparam int         CW           = AW + 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Arm,
  input  logic          Clear,
  input  logic [6:0]    PC_Out,
  input  logic [15:0]   IR_Out,
  input  logic [3:0]    State,
  output logic          RdValid,
  input  logic          RdReady,
  output logic [22:0]   RdData,
  output logic [CW-1:0] Count,
  output logic          Capturing,
  output logic          Halted,
  output logic          Overflow
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    HALTED = 2'd2
  } fsm_t;

  fsm_t          fsm_q, fsm_d;
  logic [3:0]    state_prev_q, state_prev_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [22:0]   mem_q [DEPTH];
  logic [22:0]   mem_d [DEPTH];

  logic decode_event;
  logic capture;
  logic is_halt;
  logic full;
  logic push;
  logic pop;
  logic drop;

  // One event per instruction: only the entry edge into the decode state counts.
  assign decode_event = (State == DECODE_STATE) && (state_prev_q != DECODE_STATE);
  assign capture      = decode_event && (fsm_q == ARMED) && !Clear;
  assign is_halt      = (IR_Out[15:12] == HALT_OP);
  assign full         = (count_q == CW'(DEPTH));
  assign pop          = (count_q != '0) && RdReady && !Clear;
  assign push         = capture && (!full || pop);
  assign drop         = capture && full && !pop;

  always_comb begin
    fsm_d        = fsm_q;
    state_prev_d = State;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    mem_d        = mem_q;

    if (Clear) begin
      fsm_d      = IDLE;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      case (fsm_q)
        IDLE:    if (Arm) fsm_d = ARMED;
        ARMED:   if (capture && is_halt) fsm_d = HALTED;
        default: ;
      endcase

      if (push) begin
        mem_d[wr_ptr_q] = {PC_Out, IR_Out};
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      if (drop) overflow_d = 1'b1;

      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fsm_q        <= IDLE;
      state_prev_q <= 4'h0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      fsm_q        <= fsm_d;
      state_prev_q <= state_prev_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  // Head is masked while empty so RdData reads zero whenever nothing is held.
  assign RdValid   = (count_q != '0);
  assign RdData    = RdValid ? mem_q[rd_ptr_q] : '0;
  assign Count     = count_q;
  assign Capturing = (fsm_q == ARMED);
  assign Halted    = (fsm_q == HALTED);
  assign Overflow  = overflow_q;

endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture: capture order, overflow, full push+pop,
// decode dwell, stalled drain, and Clear/Arm priority.
module tb_trace_capture;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          Arm = 1'b0;
  logic          Clear = 1'b0;
  logic [6:0]    PC_Out = '0;
  logic [15:0]   IR_Out = '0;
  logic [3:0]    State = 4'h0;
  logic          RdValid;
  logic          RdReady = 1'b0;
  logic [22:0]   RdData;
  logic [CW-1:0] Count;
  logic          Capturing;
  logic          Halted;
  logic          Overflow;

  int n_checks = 0;
  int n_fail   = 0;

  trace_capture #(.DEPTH(DEPTH), .DECODE_STATE(4'h2), .HALT_OP(4'h5)) dut (
    .Clk(Clk), .Reset(Reset), .Arm(Arm), .Clear(Clear),
    .PC_Out(PC_Out), .IR_Out(IR_Out), .State(State),
    .RdValid(RdValid), .RdReady(RdReady), .RdData(RdData),
    .Count(Count), .Capturing(Capturing), .Halted(Halted), .Overflow(Overflow)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_arm();
    Arm = 1'b1; tick(); Arm = 1'b0;
  endtask

  task automatic pulse_clear();
    Clear = 1'b1; tick(); Clear = 1'b0;
  endtask

  task automatic decode(input logic [6:0] pc, input logic [15:0] ir);
    PC_Out = pc; IR_Out = ir; State = 4'h2;
    tick();
    State = 4'h1;
    tick();
  endtask

  task automatic drain_check(input string tag, input logic [22:0] exp);
    RdReady = 1'b1;
    chk({tag, "_valid"}, RdValid, 1'b1);
    chk(tag, RdData, exp);
    tick();
    RdReady = 1'b0;
  endtask

  logic [22:0] exp_q [$];
  logic [22:0] e;
  int idx;
  int budget;

  initial begin
    // Reset state
    #1;
    chk("rst_valid", RdValid, 1'b0);
    chk("rst_data", RdData, 23'h0);
    chk("rst_count", Count, 0);
    chk("rst_capt", Capturing, 1'b0);
    chk("rst_halt", Halted, 1'b0);
    chk("rst_ovf", Overflow, 1'b0);
    tick(); tick();
    Reset = 1'b1;
    tick();

    // 1: asynchronous reset mid-capture
    pulse_arm();
    decode(7'h10, 16'h1111);
    decode(7'h11, 16'h1112);
    decode(7'h12, 16'h1113);
    chk("t1_count3", Count, 3);
    #2 Reset = 1'b0;
    #1;
    chk("t1_async_count", Count, 0);
    chk("t1_async_valid", RdValid, 1'b0);
    chk("t1_async_data", RdData, 23'h0);
    chk("t1_async_capt", Capturing, 1'b0);
    tick();
    Reset = 1'b1;
    tick();

    // 2: basic trace ending with halt
    pulse_arm();
    chk("t2_capt", Capturing, 1'b1);
    decode(7'h00, 16'h1234);
    decode(7'h01, 16'h2345);
    decode(7'h02, 16'h5000);
    chk("t2_halted", Halted, 1'b1);
    chk("t2_capt_off", Capturing, 1'b0);
    decode(7'h03, 16'h1111);
    chk("t2_count", Count, 3);
    drain_check("t2_e0", 23'h001234);
    drain_check("t2_e1", 23'h012345);
    drain_check("t2_e2", 23'h025000);
    chk("t2_empty", RdValid, 1'b0);
    chk("t2_halt_kept", Halted, 1'b1);
    pulse_clear();
    chk("t2_clr_halt", Halted, 1'b0);

    // 3: overflow with consumer stalled
    pulse_arm();
    for (int i = 0; i < DEPTH + 2; i++) decode(7'(i), 16'h1000 + 16'(i));
    chk("t3_count", Count, DEPTH);
    chk("t3_ovf", Overflow, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      e = {7'(i), 16'h1000 + 16'(i)};
      drain_check("t3_drain", e);
    end
    chk("t3_empty", RdValid, 1'b0);
    chk("t3_ovf_sticky", Overflow, 1'b1);
    pulse_clear();
    chk("t3_clr_ovf", Overflow, 1'b0);

    // 4: push and pop on the same edge while full
    pulse_arm();
    for (int i = 0; i < DEPTH; i++) decode(7'(i + 32), 16'h2000 + 16'(i));
    chk("t4_full", Count, DEPTH);
    PC_Out = 7'h40; IR_Out = 16'h3333; State = 4'h2; RdReady = 1'b1;
    tick();
    RdReady = 1'b0; State = 4'h1;
    tick();
    chk("t4_count", Count, DEPTH);
    chk("t4_ovf", Overflow, 1'b0);
    for (int i = 1; i < DEPTH; i++) begin
      e = {7'(i + 32), 16'h2000 + 16'(i)};
      drain_check("t4_drain", e);
    end
    drain_check("t4_tail", {7'h40, 16'h3333});
    chk("t4_empty", RdValid, 1'b0);
    pulse_clear();

    // 5: long decode dwell, then randomly stalled drain
    pulse_arm();
    PC_Out = 7'h11; IR_Out = 16'h7777; State = 4'h2;
    repeat (4) tick();
    State = 4'h1;
    tick();
    chk("t5_dwell", Count, 1);
    exp_q.push_back({7'h11, 16'h7777});
    for (int i = 0; i < 4; i++) begin
      decode(7'(i + 80), 16'h6000 + 16'(i * 3));
      exp_q.push_back({7'(i + 80), 16'h6000 + 16'(i * 3)});
    end
    chk("t5_count", Count, 5);
    idx = 0;
    budget = 200;
    while (idx < 5 && budget > 0) begin
      RdReady = 1'($urandom_range(0, 1));
      #1;
      if (RdValid) chk("t5_data", RdData, exp_q[idx]);
      if (RdValid && RdReady) idx++;
      tick();
      budget--;
    end
    RdReady = 1'b0;
    chk("t5_drained", idx, 5);
    chk("t5_empty", RdValid, 1'b0);
    pulse_clear();

    // 6: Clear beats Arm while halted
    pulse_arm();
    decode(7'h05, 16'h1abc);
    decode(7'h06, 16'h5abc);
    chk("t6_halted", Halted, 1'b1);
    chk("t6_count2", Count, 2);
    Clear = 1'b1; Arm = 1'b1;
    tick();
    Clear = 1'b0; Arm = 1'b0;
    chk("t6_idle", Capturing, 1'b0);
    chk("t6_halt_clr", Halted, 1'b0);
    chk("t6_count0", Count, 0);
    chk("t6_valid0", RdValid, 1'b0);
    pulse_arm();
    chk("t6_rearm", Capturing, 1'b1);
    decode(7'h22, 16'h4444);
    chk("t6_count1", Count, 1);
    chk("t6_fresh", RdData, {7'h22, 16'h4444});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
